// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: FSM states and counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package run_ctrl_pkg;

    localparam int kCYC_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } run_state_t;

endpackage

// File: rtl/run_ctrl_cyc_ctr.sv
// Up counter with synchronous clear and count enable; clear has priority.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none; counts whenever enabled.
module cyc_ctr
    import run_ctrl_pkg::*;
#(
    parameter int W = kCYC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // Count register: clear wins over enable so a restart never sees a stale value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Sequences a CPU run: holds cpu_reset for RST_CYCLES, runs until done or MAX_CYCLES, reports result.
// Latency: run starts RST_CYCLES+1 edges after start; results valid from the FIN cycle onward.
// Backpressure: start is only honoured in IDLE and never queued; cpu_done only matters in RUN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int                RST_CYCLES = 2,       // must be >= 1
    parameter logic [kCYC_W-1:0] MAX_CYCLES = 16'd1000 // must be >= 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cpu_done,
    output logic              cpu_reset,
    output logic              busy,
    output logic              finished,
    output logic              timeout,
    output logic [kCYC_W-1:0] cycles
);

    localparam logic [kCYC_W-1:0] HOLD_LAST = kCYC_W'(RST_CYCLES - 1);

    run_state_t        state_q;
    run_state_t        state_d;
    logic [kCYC_W-1:0] hold_cnt;
    logic [kCYC_W-1:0] run_cnt;
    logic [kCYC_W-1:0] run_nxt;
    logic              hold_clr;
    logic              hold_en;
    logic              run_clr;
    logic              run_en;
    logic              res_ld;
    logic              res_to;
    logic [kCYC_W-1:0] res_cyc;

    // run_cnt counts completed RUN cycles, so the current RUN cycle number is run_cnt+1.
    // It never exceeds MAX_CYCLES-1 while in RUN, so this sum cannot wrap.
    assign run_nxt = run_cnt + kCYC_W'(1);

    cyc_ctr #(.W(kCYC_W)) u_hold_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (hold_clr),
        .en    (hold_en),
        .q     (hold_cnt)
    );

    cyc_ctr #(.W(kCYC_W)) u_run_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (run_clr),
        .en    (run_en),
        .q     (run_cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter controls and result capture; done takes priority over the limit.
    always_comb begin
        state_d  = state_q;
        hold_clr = 1'b0;
        hold_en  = 1'b0;
        run_clr  = 1'b0;
        run_en   = 1'b0;
        res_ld   = 1'b0;
        res_to   = 1'b0;
        res_cyc  = run_nxt;
        case (state_q)
            IDLE: begin
                if (start) begin
                    hold_clr = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                hold_en = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    run_clr = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run_en = 1'b1;
                if (cpu_done) begin
                    res_ld  = 1'b1;
                    res_cyc = run_nxt;
                    state_d = FIN;
                end else if (run_nxt == MAX_CYCLES) begin
                    res_ld  = 1'b1;
                    res_to  = 1'b1;
                    res_cyc = MAX_CYCLES;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result registers: overwritten only when a run ends, cleared by reset (including aborts).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles  <= '0;
            timeout <= 1'b0;
        end else if (res_ld) begin
            cycles  <= res_cyc;
            timeout <= res_to;
        end
    end

    // Control outputs decode the state register only, so no input reaches them combinationally.
    assign cpu_reset = (state_q != RUN);
    assign busy      = (state_q != IDLE);
    assign finished  = (state_q == FIN);

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

    localparam int RST = 2;
    localparam int MAX = 8;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cpu_done;
    logic        cpu_reset;
    logic        busy;
    logic        finished;
    logic        timeout;
    logic [15:0] cycles;

    int n_chk;
    int n_pass;
    int fin_cnt;

    run_ctrl #(
        .RST_CYCLES (RST),
        .MAX_CYCLES (16'(MAX))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cpu_done  (cpu_done),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .finished  (finished),
        .timeout   (timeout),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model described by time since the accepted start:
    // m_s = 0 is the first cycle after start; cycles m_s >= RST are run cycles
    // numbered k = m_s-RST+1. A run ends after cycle k if done, or if k reached MAX.
    int          m_mode;   // 0 idle, 1 active, 2 finishing
    int          m_s;
    int          m_cyc;
    int          m_to;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode <= 0;
            m_s    <= 0;
            m_cyc  <= 0;
            m_to   <= 0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode <= 1;
                    m_s    <= 0;
                end
                1: begin
                    if (m_s < RST) begin
                        m_s <= m_s + 1;
                    end else if (cpu_done) begin
                        m_cyc  <= m_s - RST + 1;
                        m_to   <= 0;
                        m_mode <= 2;
                    end else if (m_s - RST + 1 == MAX) begin
                        m_cyc  <= MAX;
                        m_to   <= 1;
                        m_mode <= 2;
                    end else begin
                        m_s <= m_s + 1;
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int e_rst, e_busy, e_fin;
        e_busy = (m_mode != 0) ? 1 : 0;
        e_fin  = (m_mode == 2) ? 1 : 0;
        e_rst  = (m_mode == 1 && m_s >= RST) ? 0 : 1;
        if (finished) fin_cnt = fin_cnt + 1;
        n_chk = n_chk + 1;
        if (cpu_reset === 1'(e_rst) && busy === 1'(e_busy) && finished === 1'(e_fin) &&
            timeout === 1'(m_to) && cycles === 16'(m_cyc)) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL cycle_cmp: got rst=%b busy=%b fin=%b to=%b cyc=%0d expected rst=%0d busy=%0d fin=%0d to=%0d cyc=%0d at %0t",
                     cpu_reset, busy, finished, timeout, cycles, e_rst, e_busy, e_fin, m_to, m_cyc, $time);
        end
    end

    // One run from a negedge: start pulse, optional ignored noise, done in run
    // cycle done_at (0 = never, i.e. timeout). Returns at the first IDLE negedge.
    task automatic run(input int done_at, input bit noise);
        int len;
        int f0;
        len = (done_at == 0) ? MAX : done_at;
        f0  = fin_cnt;
        start    = 1'b1;
        cpu_done = 1'b0;
        for (int j = 1; j <= RST + len + 1; j++) begin
            @(negedge clk);
            start    = noise && (j == 1 || j == RST + 2 || j == RST + len + 1);
            cpu_done = (noise && j <= RST) ||
                       (done_at != 0 && j == RST + done_at) ||
                       (noise && j == RST + len + 1 && $urandom_range(1) == 1);
        end
        @(negedge clk);
        start    = 1'b0;
        cpu_done = 1'b0;
        chk("fin_pulses", fin_cnt - f0, 1);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start    = 1'b0;
            cpu_done = 1'($urandom_range(1));
        end
        @(negedge clk);
        cpu_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        n_chk = 0; n_pass = 0; fin_cnt = 0;
        reset = 1'b0; start = 1'b0; cpu_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_reset", int'(cpu_reset), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_finished", int'(finished), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_cycles", int'(cycles), 0);

        // Start on the very edge after reset release; done in 5th run cycle.
        reset = 1'b1;
        run(5, 1'b0);
        chk("done5_cycles", int'(cycles), 5);
        chk("done5_timeout", int'(timeout), 0);

        // Timeout with done held low.
        gap(2);
        run(0, 1'b0);
        chk("tmo_cycles", int'(cycles), 8);
        chk("tmo_timeout", int'(timeout), 1);
        chk("tmo_cpu_reset", int'(cpu_reset), 1);

        // Done coincides with the limit: done wins.
        gap(1);
        run(MAX, 1'b0);
        chk("lim_done_cycles", int'(cycles), 8);
        chk("lim_done_timeout", int'(timeout), 0);

        // Extra start pulses and done during hold are ignored.
        gap(1);
        run(4, 1'b1);
        chk("noise_cycles", int'(cycles), 4);

        // Back-to-back runs.
        run(3, 1'b0);
        chk("b2b_first", int'(cycles), 3);
        run(7, 1'b0);
        chk("b2b_second", int'(cycles), 7);

        // Asynchronous abort in the 3rd run cycle.
        f0 = fin_cnt;
        start = 1'b1;
        for (int j = 1; j <= RST + 3; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 reset = 1'b0;
        #1;
        chk("abort_cpu_reset", int'(cpu_reset), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_finished", int'(finished), 0);
        chk("abort_timeout", int'(timeout), 0);
        chk("abort_cycles", int'(cycles), 0);
        repeat (2) @(negedge clk);
        chk("abort_no_fin", fin_cnt - f0, 0);
        reset = 1'b1;
        run(4, 1'b0);
        chk("after_abort_cycles", int'(cycles), 4);

        // Randomized runs checked by the model every cycle.
        for (int r = 0; r < 40; r++) begin
            gap($urandom_range(3));
            run($urandom_range(MAX), 1'($urandom_range(1)));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2: number of cycles cpu_reset is held high after a start.
REQ-002 Parameter MAX_CYCLES, default 16'd1000: run-length limit before timeout; legal range 1..65535.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a program run; sampled only in IDLE.
REQ-006 cpu_done  input  1  the CPU's done flag (halt instruction fetched).
REQ-007 cpu_reset  output  1  active-high reset driven to the CPU core.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 finished  output  1  one-cycle pulse when a run ends, by done or by timeout.
REQ-010 timeout  output  1  result flag: the last run hit MAX_CYCLES without cpu_done.
REQ-011 cycles  output  16  result count: run cycles consumed by the last run.

Function
REQ-012 FSM states SHALL be IDLE, HOLD, RUN and FIN; there are no other reachable states.
REQ-013 IDLE: cpu_reset=1 and busy=0; start=1 SHALL move to HOLD and clear the hold counter.
REQ-014 HOLD: cpu_reset=1; after exactly RST_CYCLES cycles in HOLD, go to RUN and clear the run counter.
REQ-015 RUN: cpu_reset=0; the run counter SHALL increment by 1 on every RUN-state edge.
REQ-016 RUN exit on cpu_done=1: go to FIN; cycles = run counter + 1 (done in the first RUN cycle gives 1); timeout=0.
REQ-017 RUN exit on limit: if run counter + 1 == MAX_CYCLES and cpu_done=0, go to FIN with cycles=MAX_CYCLES and timeout=1.
REQ-018 Simultaneous cpu_done and limit: done wins; timeout=0 and cycles=MAX_CYCLES.
REQ-019 FIN lasts one cycle with finished=1 and cpu_reset=1, then returns to IDLE.
REQ-020 cycles and timeout are registered; they hold their value until the next run's FIN overwrites them.
REQ-021 start SHALL be ignored in HOLD, RUN and FIN; it is not queued.
REQ-022 cpu_done SHALL be ignored outside RUN.
REQ-023 The run counter is 16 bits and SHALL never wrap, because REQ-017 bounds it.
REQ-024 cpu_reset, busy and finished SHALL be decoded from state registers only, with no combinational path from inputs.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, cpu_reset=1, busy=0, finished=0, timeout=0, cycles=0, and both counters to 0.
REQ-026 Reset asserted mid-run SHALL abort the run with no finished pulse; results clear to 0.
REQ-027 After reset deasserts, the first start is accepted on the next rising edge.

Structure
REQ-028 The shared definitions package SHALL hold typedef run_state_t (IDLE, HOLD, RUN, FIN) and constant kCYC_W=16.
REQ-029 One sub-module, cyc_ctr, SHALL be used: a kCYC_W-bit up counter with clear and enable, instantiated for both the hold count and the run count.
REQ-030 run_ctrl sits upstream of the CPU top: cpu_reset drives the top's reset port, and the top's done output drives cpu_done.

Verification
REQ-031 Reset then 1-cycle start pulse; cpu_done rises on the 5th RUN cycle -> cpu_reset high for 2 cycles then low; finished pulses once; cycles=5, timeout=0.
REQ-032 MAX_CYCLES=8, cpu_done held 0 -> finished after 8 RUN cycles; cycles=8, timeout=1, cpu_reset back to 1.
REQ-033 MAX_CYCLES=8, cpu_done rises on the 8th RUN cycle -> cycles=8, timeout=0.
REQ-034 start pulsed again during RUN and cpu_done=1 during HOLD -> both ignored; the run ends by the normal rules with a single finished pulse.
REQ-035 reset asserted on the 3rd RUN cycle -> all outputs reach reset values asynchronously with no finished pulse; a new start then gives a clean run with cycles counted from 1.
REQ-036 Back-to-back runs (3 cycles, then 7 cycles) -> cycles holds 3 until the second FIN, then reads 7.
